// File: rtl/ac_motor_pwm_gate_if.sv
// ac_motor_pwm_gate_if: carrier, duty and direction inputs plus H-bridge gate outputs
interface ac_motor_pwm_gate_if #(
  parameter int CARRIER_W = 25,
  parameter int DUTY_W = 24
);
  logic signed [CARRIER_W-1:0] triangle;
  logic lock;
  logic cw_in;
  logic ccw_in;
  logic [DUTY_W-1:0] duty;
  logic hs_a;
  logic ls_a;
  logic hs_b;
  logic ls_b;
  logic fault;
  modport master (
    output triangle, lock, cw_in, ccw_in, duty,
    input hs_a, ls_a, hs_b, ls_b, fault
  );
  modport slave (
    input triangle, lock, cw_in, ccw_in, duty,
    output hs_a, ls_a, hs_b, ls_b, fault
  );
endinterface

// File: rtl/ac_motor_pwm_gate.sv
// ac_motor_pwm_gate: carrier compare with per-leg dead-time FSMs and a LOCK watchdog
module ac_motor_pwm_gate #(
  parameter int CARRIER_W = 25,
  parameter int DUTY_W = 24,
  parameter int DEAD_CYCLES = 41,
  parameter int LOCK_TIMEOUT = 40000
) (
  input logic CLK,
  input logic RST,
  ac_motor_pwm_gate_if.slave io
);
  typedef enum logic [1:0] {COAST, DRIVE_CW, DRIVE_CCW, BRAKE} mode_t;
  typedef enum logic [1:0] {OFF, HIGH, LOW, DEAD} leg_t;
  localparam int RW = CARRIER_W + 1;
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int WW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [DUTY_W-1:0] FULL = {1'b0, {(DUTY_W-1){1'b1}}};
  logic lock_d, lock_rise, fault;
  mode_t mode;
  logic [DUTY_W-1:0] duty_q;
  logic [WW-1:0] wd;
  logic signed [RW-1:0] mag, ref_a, ref_b, carrier;
  assign lock_rise = io.lock & ~lock_d;
  assign mag = signed'(RW'(duty_q));
  assign ref_a = (mode == DRIVE_CCW) ? -mag : mag;
  assign ref_b = -ref_a;
  assign carrier = RW'(io.triangle);
  // {ccw,cw} maps directly onto the mode encoding: 00 coast, 01 cw, 10 ccw, 11 brake
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_d <= 1'b0;
      mode <= COAST;
      duty_q <= '0;
      wd <= '0;
      fault <= 1'b0;
    end else begin
      lock_d <= io.lock;
      if (lock_rise) begin
        duty_q <= io.duty > FULL ? FULL : io.duty;
        mode <= mode_t'({io.ccw_in, io.cw_in});
      end
      wd <= lock_rise ? '0 : (wd == WW'(LOCK_TIMEOUT) ? wd : wd + 1'b1);
      fault <= fault | (wd == WW'(LOCK_TIMEOUT));
    end
  end
  for (genvar g = 0; g < 2; g++) begin : g_leg
    leg_t want_d, want_q, want_e, st, st_n;
    logic [DW-1:0] cnt, cnt_n;
    logic signed [RW-1:0] r;
    logic hs, ls;
    assign r = g == 0 ? ref_a : ref_b;
    assign want_e = fault ? OFF : want_q;
    always_comb want_d = mode == COAST ? OFF : mode == BRAKE ? LOW : (r > carrier ? HIGH : LOW);
    // turn-off and start-from-off are immediate; only a side swap passes through DEAD
    always_comb begin
      st_n = st;
      cnt_n = cnt;
      if (st == DEAD) begin
        st_n = cnt == '0 ? want_e : DEAD;
        cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
      end else if (st == OFF || want_e == OFF || want_e == st) begin
        st_n = want_e;
      end else begin
        st_n = DEAD;
        cnt_n = DW'(DEAD_CYCLES - 1);
      end
    end
    always_ff @(posedge CLK) begin
      if (RST) begin
        want_q <= OFF;
        st <= OFF;
        cnt <= '0;
        hs <= 1'b0;
        ls <= 1'b0;
      end else begin
        want_q <= want_d;
        st <= st_n;
        cnt <= cnt_n;
        hs <= st == HIGH;
        ls <= st == LOW;
      end
    end
  end
  assign io.hs_a = g_leg[0].hs;
  assign io.ls_a = g_leg[0].ls;
  assign io.hs_b = g_leg[1].hs;
  assign io.ls_b = g_leg[1].ls;
  assign io.fault = fault;
endmodule
